// File: rtl/sipo_deser.sv
// sipo_deser: serial-to-parallel deserializer with bit counter, word framing,
// a valid/ready holding register, selectable bit order and a sticky overflow.
// Optional feature macro: SIPO_DESER_PARITY_CHECK_EN
//   defined   -> each frame is WIDTH data bits plus one even-parity bit and
//                parity_err reports the parity check of the word held in q.
//   undefined -> frames are WIDTH bits and parity_err is tied to 0.
// Reset rst is asynchronous and active-low; clr is a synchronous clear.

module sipo_deser #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0,
  localparam int CNT_W    = $clog2(WIDTH + 2)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             shift_en,
  input  logic             data_in,
  input  logic             q_ready,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             overflow,
  output logic             parity_err
);

`ifdef SIPO_DESER_PARITY_CHECK_EN
  localparam int FLEN = WIDTH + 1;
`else
  localparam int FLEN = WIDTH;
`endif

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FLEN - 1);

  // Holding register occupancy: EMPTY means q_valid=0, FULL means q_valid=1.
  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } hold_state_t;

  hold_state_t      state;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_next;
  logic [WIDTH-1:0] word;
  logic             frame_done;
  logic             word_par_err;
  logic             perr_reg;

  // Next shift-register contents with the incoming bit inserted per bit order.
  always_comb begin
    sr_next = sr;
    if (MSB_FIRST) begin
      sr_next = {sr[WIDTH-2:0], data_in};
    end else begin
      sr_next = {data_in, sr[WIDTH-1:1]};
    end
  end

  // Frame completion and the word it delivers.
  always_comb begin
    frame_done = shift_en && (bit_cnt == LAST_CNT);
`ifdef SIPO_DESER_PARITY_CHECK_EN
    // The final bit is the parity bit; sr already holds all data bits.
    word         = sr;
    word_par_err = (^sr) ^ data_in;
`else
    // The final bit is a data bit and completes the word on this edge.
    word         = sr_next;
    word_par_err = 1'b0;
`endif
  end

  assign q_valid = (state == S_FULL);

  // Bit counting, shifting and the EMPTY/FULL holding-register machine.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_EMPTY;
      sr       <= '0;
      q        <= '0;
      bit_cnt  <= '0;
      overflow <= 1'b0;
      perr_reg <= 1'b0;
    end else if (clr) begin
      state    <= S_EMPTY;
      sr       <= '0;
      q        <= '0;
      bit_cnt  <= '0;
      overflow <= 1'b0;
      perr_reg <= 1'b0;
    end else begin
      if (shift_en) begin
        if (frame_done) begin
          bit_cnt <= '0;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
`ifdef SIPO_DESER_PARITY_CHECK_EN
        // The parity bit is never stored in sr.
        if (!frame_done) begin
          sr <= sr_next;
        end
`else
        sr <= sr_next;
`endif
      end

      case (state)
        S_EMPTY: begin
          // q_ready is ignored while nothing is held.
          if (frame_done) begin
            q        <= word;
            perr_reg <= word_par_err;
            state    <= S_FULL;
          end
        end
        S_FULL: begin
          if (frame_done) begin
            if (q_ready) begin
              // Transfer and completion on the same edge: reload, stay FULL.
              q        <= word;
              perr_reg <= word_par_err;
            end else begin
              // Consumer still holds off: drop the new word and flag it.
              overflow <= 1'b1;
            end
          end else if (q_ready) begin
            // Plain transfer; q keeps its last value.
            state <= S_EMPTY;
          end
        end
        default: state <= S_EMPTY;
      endcase
    end
  end

`ifdef SIPO_DESER_PARITY_CHECK_EN
  assign parity_err = perr_reg;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_deser.sv
// Testbench for sipo_deser: two instances (LSB-first and MSB-first) share one
// stimulus stream and are compared every cycle against a frame-level model.
module tb_sipo_deser;

  localparam int WIDTH = 8;
  localparam int CNT_W = $clog2(WIDTH + 2);
`ifdef SIPO_DESER_PARITY_CHECK_EN
  localparam int FLEN = WIDTH + 1;
`else
  localparam int FLEN = WIDTH;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clr = 1'b0;
  logic shift_en = 1'b0;
  logic data_in = 1'b0;
  logic q_ready = 1'b0;

  logic [WIDTH-1:0] q0, q1;
  logic             v0, v1, of0, of1, pe0, pe1;
  logic [CNT_W-1:0] c0, c1;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sipo_deser #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .clr(clr), .shift_en(shift_en), .data_in(data_in),
    .q_ready(q_ready), .q(q0), .q_valid(v0), .bit_cnt(c0), .overflow(of0),
    .parity_err(pe0)
  );

  sipo_deser #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst(rst), .clr(clr), .shift_en(shift_en), .data_in(data_in),
    .q_ready(q_ready), .q(q1), .q_valid(v1), .bit_cnt(c1), .overflow(of1),
    .parity_err(pe1)
  );

  // Frame-level model: collects received bits, assembles a word once a
  // whole frame has arrived, and tracks the holding register by its rules.
  logic             bits[$];
  logic [WIDTH-1:0] m_q0, m_q1;
  logic             m_valid, m_ovf, m_perr;

  task automatic model_clear();
    bits.delete();
    m_q0 = '0; m_q1 = '0; m_valid = 1'b0; m_ovf = 1'b0; m_perr = 1'b0;
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      model_clear();
    end else if (clr) begin
      model_clear();
    end else begin
      logic             done;
      logic [WIDTH-1:0] w0, w1;
      logic             par;
      done = 1'b0; w0 = '0; w1 = '0; par = 1'b0;
      if (shift_en) begin
        bits.push_back(data_in);
        if (bits.size() == FLEN) begin
          done = 1'b1;
          for (int i = 0; i < WIDTH; i++) begin
            w0[i] = bits[i];
            w1[WIDTH-1-i] = bits[i];
          end
          for (int i = 0; i < FLEN; i++) par = par ^ bits[i];
`ifndef SIPO_DESER_PARITY_CHECK_EN
          par = 1'b0;
`endif
          bits.delete();
        end
      end
      if (done) begin
        if (!m_valid || q_ready) begin
          m_q0 = w0; m_q1 = w1; m_perr = par; m_valid = 1'b1;
        end else begin
          m_ovf = 1'b1;
        end
      end else if (m_valid && q_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    chk("q_lsb", 32'(q0), 32'(m_q0));
    chk("q_msb", 32'(q1), 32'(m_q1));
    chk("q_valid_lsb", 32'(v0), 32'(m_valid));
    chk("q_valid_msb", 32'(v1), 32'(m_valid));
    chk("bit_cnt_lsb", 32'(c0), 32'(bits.size()));
    chk("bit_cnt_msb", 32'(c1), 32'(bits.size()));
    chk("overflow_lsb", 32'(of0), 32'(m_ovf));
    chk("overflow_msb", 32'(of1), 32'(m_ovf));
    chk("parity_err_lsb", 32'(pe0), 32'(m_perr));
    chk("parity_err_msb", 32'(pe1), 32'(m_perr));
  end

  task automatic step(input logic sh, input logic d, input logic rdy, input logic c);
    shift_en = sh; data_in = d; q_ready = rdy; clr = c;
    @(posedge clk);
    #1;
  endtask

  // Sends bits s[0..n-1] in that order; rdy_last drives q_ready on the final bit.
  task automatic send(input logic [15:0] s, input int n, input logic rdy_last);
    for (int i = 0; i < n; i++) step(1'b1, s[i], (i == n - 1) ? rdy_last : 1'b0, 1'b0);
  endtask

  // Full frame: 8 data bits plus, when parity is built in, an even-parity bit.
  task automatic send_frame(input logic [7:0] d, input logic par_bit, input logic rdy_last);
`ifdef SIPO_DESER_PARITY_CHECK_EN
    send({7'd0, par_bit, d}, 9, rdy_last);
`else
    if (par_bit) begin end
    send({8'd0, d}, 8, rdy_last);
`endif
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_q", 32'(q0), 32'h0);
    chk("reset_valid", 32'(v0), 32'h0);
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // LSB/MSB order: bits 1,0,1,1,0,0,1,0
    send_frame(8'h4D, 1'b0, 1'b0);
    chk("lsb_word", 32'(q0), 32'h4D);
    chk("msb_word", 32'(q1), 32'hB2);
    chk("word_valid", 32'(v0), 32'h1);
    chk("cnt_after_word", 32'(c0), 32'h0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("after_xfer_valid", 32'(v0), 32'h0);
    chk("after_xfer_q", 32'(q0), 32'h4D);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // Gapped frame
    send(16'h000D, 4, 1'b0);
    for (int g = 0; g < 3; g++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0);
      chk("gap_cnt", 32'(c0), 32'h4);
    end
`ifdef SIPO_DESER_PARITY_CHECK_EN
    send(16'h0004, 5, 1'b0);
`else
    send(16'h0004, 4, 1'b0);
`endif
    chk("gap_word", 32'(q0), 32'h4D);
    step(1'b0, 1'b0, 1'b1, 1'b0);

    // Overflow: two frames with no acceptance
    send_frame(8'h4D, 1'b0, 1'b0);
    send_frame(8'hA5, 1'b0, 1'b0);
    chk("ovf_flag", 32'(of0), 32'h1);
    chk("ovf_keep_q", 32'(q0), 32'h4D);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("ovf_sticky", 32'(of0), 32'h1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    chk("clr_ovf", 32'(of0), 32'h0);
    chk("clr_cnt", 32'(c0), 32'h0);

    // Back-to-back with acceptance on the second completion edge
    send_frame(8'h4D, 1'b0, 1'b0);
    send_frame(8'hA5, 1'b0, 1'b1);
    chk("b2b_word", 32'(q0), 32'hA5);
    chk("b2b_valid", 32'(v0), 32'h1);
    chk("b2b_no_ovf", 32'(of0), 32'h0);
    step(1'b0, 1'b0, 1'b1, 1'b0);

`ifdef SIPO_DESER_PARITY_CHECK_EN
    send_frame(8'h4D, 1'b0, 1'b0);
    chk("parity_ok", 32'(pe0), 32'h0);
    send_frame(8'h4D, 1'b1, 1'b1);
    chk("parity_bad", 32'(pe0), 32'h1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
`else
    chk("parity_tied", 32'(pe0), 32'h0);
`endif

    // Asynchronous reset mid-frame
    send(16'h0005, 3, 1'b0);
    chk("cnt_mid", 32'(c0), 32'h3);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    chk("async_cnt", 32'(c0), 32'h0);
    chk("async_q", 32'(q0), 32'h0);
    chk("async_valid", 32'(v0), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    step(1'b1, 1'b1, 1'b0, 1'b1);
    chk("clr_shift_cnt", 32'(c0), 32'h0);
    chk("clr_shift_valid", 32'(v0), 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
